// File: rtl/enemy_bullet_if.sv
// Display-side bundle for the enemy bullet: geometry, in-flight flag and colour.
interface enemy_bullet_if;
  logic       bullet_o;
  logic [9:0] bullet_left_o;
  logic [9:0] bullet_right_o;
  logic [9:0] bullet_top_o;
  logic [9:0] bullet_bot_o;
  logic [3:0] bullet_red_o;
  logic [3:0] bullet_green_o;
  logic [3:0] bullet_blue_o;

  modport master (
    output bullet_o, bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
    output bullet_red_o, bullet_green_o, bullet_blue_o
  );

  modport slave (
    input bullet_o, bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o,
    input bullet_red_o, bullet_green_o, bullet_blue_o
  );
endinterface

// File: rtl/enemy_bullet.sv
// Enemy bullet shooter: reload/fly FSM, per-frame stepping, player hit detection.
// Optional macro ENEMY_BULLET_JITTER_EN adds an LFSR-randomised reload period.
module enemy_bullet #(
  parameter logic [11:0] color_p       = {4'hF, 4'h5, 4'h5},
  parameter logic [9:0]  fire_period_p = 10'd60,
  parameter logic [9:0]  step_p        = 10'd6,
  parameter logic [9:0]  floor_p       = 10'd470,
  parameter logic [9:0]  player_top_p  = 10'd400,
  parameter logic [9:0]  player_bot_p  = 10'd420
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  frame_i,
  input  logic                  enable_i,
  input  logic [9:0]            shooter_x_i,
  input  logic [9:0]            shooter_bot_i,
  input  logic [9:0]            player_left_i,
  input  logic [9:0]            player_right_i,
  output logic                  hit_o,
  output logic [1:0]            state_o,
  enemy_bullet_if.master        bus
);

  typedef enum logic [1:0] {
    RELOAD = 2'b01,
    FLYING = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] cooldown_q, cooldown_d;
  logic [9:0] left_q, left_d;
  logic [9:0] top_q, top_d;
  logic       bullet_q, bullet_d;

  logic [9:0]  right_s;
  logic [9:0]  bot_s;
  logic [10:0] top_step_s;
  logic        overlap_s;
  logic        floor_s;
  logic        hit_s;
  logic [9:0]  reload_s;

  assign right_s    = left_q + 10'd6;
  assign bot_s      = top_q + 10'd10;
  assign top_step_s = {1'b0, top_q} + {1'b0, step_p};
  assign floor_s    = (top_step_s >= {1'b0, floor_p});
  assign overlap_s  = (right_s > player_left_i) && (left_q < player_right_i) &&
                      (bot_s >= player_top_p) && (top_q <= player_bot_p);

`ifdef ENEMY_BULLET_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb_s;

  assign lfsr_fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign reload_s  = fire_period_p + {6'd0, lfsr_q[3:0]};

  // LFSR advances once per frame tick regardless of game state.
  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end
`else
  assign reload_s = fire_period_p;
`endif

  // Next-state logic: pause overrides everything, then hit > floor > step.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    left_d     = left_q;
    top_d      = top_q;
    hit_s      = 1'b0;
    if (!enable_i) begin
      state_d    = RELOAD;
      cooldown_d = reload_s;
    end else begin
      case (state_q)
        RELOAD: begin
          if (frame_i) begin
            if (cooldown_q == 10'd0) begin
              left_d  = shooter_x_i;
              top_d   = shooter_bot_i;
              state_d = FLYING;
            end else begin
              cooldown_d = cooldown_q - 10'd1;
            end
          end else begin
            cooldown_d = cooldown_q;
          end
        end
        FLYING: begin
          if (frame_i) begin
            if (overlap_s) begin
              hit_s      = 1'b1;
              state_d    = RELOAD;
              cooldown_d = reload_s;
            end else if (floor_s) begin
              state_d    = RELOAD;
              cooldown_d = reload_s;
            end else begin
              top_d = top_step_s[9:0];
            end
          end else begin
            top_d = top_q;
          end
        end
        default: begin
          state_d    = RELOAD;
          cooldown_d = reload_s;
        end
      endcase
    end
    bullet_d = (state_d == FLYING);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= RELOAD;
      cooldown_q <= fire_period_p;
      left_q     <= 10'd0;
      top_q      <= 10'd0;
      bullet_q   <= 1'b0;
`ifdef ENEMY_BULLET_JITTER_EN
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
      left_q     <= left_d;
      top_q      <= top_d;
      bullet_q   <= bullet_d;
`ifdef ENEMY_BULLET_JITTER_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  // hit_o is Mealy so it lines up with the frame tick; suppressed during reset.
  assign hit_o   = hit_s & reset_ni;
  assign state_o = state_q;

  assign bus.bullet_o       = bullet_q;
  assign bus.bullet_left_o  = left_q;
  assign bus.bullet_right_o = right_s;
  assign bus.bullet_top_o   = top_q;
  assign bus.bullet_bot_o   = bot_s;
  assign bus.bullet_red_o   = color_p[11:8];
  assign bus.bullet_green_o = color_p[7:4];
  assign bus.bullet_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_enemy_bullet.sv
// Scoreboard bench for enemy_bullet: every output change is matched against a
// queued expected snapshot and the cycle in which it must appear.
module tb_enemy_bullet;
  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       frame_i = 1'b0;
  logic       enable_i = 1'b1;
  logic [9:0] shooter_x_i = 10'd100;
  logic [9:0] shooter_bot_i = 10'd50;
  logic [9:0] player_left_i = 10'd90;
  logic [9:0] player_right_i = 10'd130;
  logic       hit_o;
  logic [1:0] state_o;

  enemy_bullet_if bus ();

  enemy_bullet #(.fire_period_p(10'd2)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .frame_i        (frame_i),
    .enable_i       (enable_i),
    .shooter_x_i    (shooter_x_i),
    .shooter_bot_i  (shooter_bot_i),
    .player_left_i  (player_left_i),
    .player_right_i (player_right_i),
    .hit_o          (hit_o),
    .state_o        (state_o),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bl;
    logic [9:0] l;
    logic [9:0] r;
    logic [9:0] t;
    logic [9:0] b;
    logic [1:0] st;
    logic       h;
    logic [11:0] rgb;
  } snap_t;

  snap_t exp_q[$];
  int    cyc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cnt = 0;
  bit    mon_en = 1'b0;
  bit    first = 1'b1;
  snap_t prev;
  snap_t cur;
  snap_t e;
  int    ec;

  logic       e_bl = 1'b0;
  logic [9:0] e_l = 10'd0;
  logic [9:0] e_t = 10'd0;
  logic [1:0] e_st = 2'b01;

  always @(posedge clk) cnt <= cnt + 1;

  function automatic string fmt(snap_t s);
    return $sformatf("bullet=%0d l=%0d r=%0d t=%0d b=%0d st=%b hit=%0d rgb=%h",
                     s.bl, s.l, s.r, s.t, s.b, s.st, s.h, s.rgb);
  endfunction

  // Monitor: any change of the observable outputs consumes one expectation.
  always @(negedge clk) begin
    cur.bl  = bus.bullet_o;
    cur.l   = bus.bullet_left_o;
    cur.r   = bus.bullet_right_o;
    cur.t   = bus.bullet_top_o;
    cur.b   = bus.bullet_bot_o;
    cur.st  = state_o;
    cur.h   = hit_o;
    cur.rgb = {bus.bullet_red_o, bus.bullet_green_o, bus.bullet_blue_o};
    if (mon_en) begin
      if (first || (cur !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cycle %0d: got %s", cnt, fmt(cur));
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          if ((cur !== e) || (ec != cnt)) begin
            errors++;
            $display("FAIL output_event: got cycle %0d %s ; required cycle %0d %s",
                     cnt, fmt(cur), ec, fmt(e));
          end
        end
        first = 1'b0;
      end
      prev = cur;
    end
  end

  task automatic push(input logic h, input int delay);
    snap_t s;
    s.bl  = e_bl;
    s.l   = e_l;
    s.r   = e_l + 10'd6;
    s.t   = e_t;
    s.b   = e_t + 10'd10;
    s.st  = e_st;
    s.h   = h;
    s.rgb = 12'hF55;
    exp_q.push_back(s);
    cyc_q.push_back(cnt + delay);
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  // One frame pulse followed by two idle cycles in which nothing may move.
  task automatic tick();
    frame_i = 1'b1;
    cyc1();
    frame_i = 1'b0;
    cyc1();
    cyc1();
  endtask

  // Two silent cooldown frames, then the firing frame.
  task automatic fire(input logic [9:0] x);
    tick();
    tick();
    e_bl = 1'b1; e_l = x; e_t = 10'd50; e_st = 2'b10;
    push(1'b0, 1);
    tick();
  endtask

  task automatic step_to(input logic [9:0] target);
    while (e_t != target) begin
      e_t = e_t + 10'd6;
      push(1'b0, 1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    // Reset held for two edges with frame pulsing.
    reset_ni = 1'b0;
    frame_i  = 1'b1;
    cyc1();
    cyc1();
    push(1'b0, 0);
    mon_en   = 1'b1;
    reset_ni = 1'b1;
    frame_i  = 1'b0;
    cyc1();
    cyc1();

    // First shot, then flight with shooter_x moved away (left must stay 100).
    fire(10'd100);
    shooter_x_i = 10'd200;
    step_to(10'd68);

    // Continue down to the hit frame at top=392.
    step_to(10'd392);
    push(1'b1, 0);
    e_bl = 1'b0; e_st = 2'b01;
    push(1'b0, 1);
    tick();

    // Miss: player moved out of the bullet's column; retire at top=464.
    player_left_i  = 10'd300;
    player_right_i = 10'd340;
    shooter_x_i    = 10'd100;
    fire(10'd100);
    step_to(10'd464);
    e_bl = 1'b0; e_st = 2'b01;
    push(1'b0, 1);
    tick();

    // Pause mid-flight at top=200.
    fire(10'd100);
    step_to(10'd200);
    enable_i = 1'b0;
    e_bl = 1'b0; e_st = 2'b01;
    push(1'b0, 1);
    cyc1();
    cyc1();
    enable_i = 1'b1;
    cyc1();

    // Reset mid-flight at top=200.
    fire(10'd100);
    step_to(10'd200);
    reset_ni = 1'b0;
    e_bl = 1'b0; e_l = 10'd0; e_t = 10'd0; e_st = 2'b01;
    push(1'b0, 1);
    cyc1();
    reset_ni = 1'b1;
    cyc1();

    // Cooldown restarts from its reset value after reset.
    fire(10'd100);
    cyc1();
    cyc1();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
